// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues word addresses to a registered-read
// instruction memory and queues the returned words in a two-entry FIFO for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] ipc_q;
  logic        inflight_q;
  logic [1:0]  count_q, count_d;
  logic        hd_q, hd_d;
  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic        tl;
  logic [2:0]  occ;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en)  state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pop  = out_valid & out_ready;
  assign push = inflight_q & ~redirect_valid;
  // Occupancy once this cycle's pop and the pending response are accounted for.
  assign occ  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  // Issue follows the state being entered, so fetch starts the cycle fetch_en is seen.
  assign issue = (state_d == RUN) & fetch_en & ~redirect_valid & (occ < 3'd2);
  // Tail slot; when full, a same-cycle pop frees the head slot that this aliases.
  assign tl = hd_q ^ count_q[0];

  always_comb begin
    hd_d    = hd_q;
    count_d = count_q;
    fpc_d   = fpc_q;
    if (pop) hd_d = ~hd_q;
    if (redirect_valid) begin
      count_d = 2'd0;
      fpc_d   = redirect_pc;
    end else begin
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (issue) fpc_d = fpc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      hd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= issue;
      count_q    <= count_d;
      hd_q       <= hd_d;
    end
  end

  // Datapath storage carries no reset; validity is tracked by inflight_q/count_q.
  always_ff @(posedge clk) begin
    if (issue) ipc_q <= fpc_q;
    if (push) begin
      buf_pc_q[tl]    <= ipc_q;
      buf_instr_q[tl] <= imem_instr;
    end
  end

  assign imem_pc   = fpc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = out_valid ? buf_pc_q[hd_q]    : 32'd0;
  assign out_instr = out_valid ? buf_instr_q[hd_q] : 32'd0;

endmodule
